// File: rtl/uart_pkg.sv
// Shared UART types and parameter limits, used by the transmitter and the
// planned receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;
    localparam int OVERSAMPLE_MIN = 2;
    localparam int OVERSAMPLE_MAX = 32;

    // Words narrower than DATA_BITS_MAX are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_of(input logic [DATA_BITS_MAX-1:0] word,
                                       input parity_t mode);
        case (mode)
            PARITY_EVEN: return ^word;
            PARITY_ODD:  return ~^word;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity, STOP_BITS stop bits; one bit lasts OVERSAMPLE ticks.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int      DATA_BITS  = 8,
    parameter parity_t PARITY     = PARITY_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_LAST      = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_ONE       = SW'(1);
    localparam logic [NW-1:0] N_DATA_LAST = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] N_STOP_LAST = NW'(STOP_BITS - 1);
    localparam logic [NW-1:0] N_ONE       = NW'(1);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS=%0d outside %0d..%0d",
               DATA_BITS, DATA_BITS_MIN, DATA_BITS_MAX);
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS=%0d outside %0d..%0d",
               STOP_BITS, STOP_BITS_MIN, STOP_BITS_MAX);
    end
    if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX) begin : g_bad_oversample
        $error("uart_tx_frame: OVERSAMPLE=%0d outside %0d..%0d",
               OVERSAMPLE, OVERSAMPLE_MIN, OVERSAMPLE_MAX);
    end

    tx_state_t            state_q, state_d;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [NW-1:0]        n_cnt_q, n_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    assign bit_end  = tick && (s_cnt_q == S_LAST);
    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = !tx_ready;
    assign tx       = tx_q;
    assign tx_done  = done_q;

    // tx_d always carries the level of the bit the FSM enters next, so tx is a plain flop.
    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    state_d = START;
                    s_cnt_d = '0;
                    n_cnt_d = '0;
                    shreg_d = tx_data;
                    par_d   = parity_of(DATA_BITS_MAX'(tx_data), PARITY);
                    tx_d    = 1'b0;
                end
            end
            default: begin
                if (tick) begin
                    s_cnt_d = bit_end ? '0 : s_cnt_q + S_ONE;
                end
                if (bit_end) begin
                    case (state_q)
                        START: begin
                            state_d = DATA;
                            tx_d    = shreg_q[0];
                        end
                        DATA: begin
                            shreg_d = shreg_q >> 1;
                            if (n_cnt_q == N_DATA_LAST) begin
                                n_cnt_d = '0;
                                if (PARITY != PARITY_NONE) begin
                                    state_d = PAR;
                                    tx_d    = par_q;
                                end else begin
                                    state_d = STOP;
                                    tx_d    = 1'b1;
                                end
                            end else begin
                                n_cnt_d = n_cnt_q + N_ONE;
                                tx_d    = shreg_q[1];
                            end
                        end
                        PAR: begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                        STOP: begin
                            if (n_cnt_q == N_STOP_LAST) begin
                                state_d = IDLE;
                                n_cnt_d = '0;
                                done_d  = 1'b1;
                                tx_d    = 1'b1;
                            end else begin
                                n_cnt_d = n_cnt_q + N_ONE;
                            end
                        end
                        default: begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Shift register and parity are only meaningful inside a frame and need no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        par_q   <= par_d;
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 7E1, 7O1, 8N2) share
// clk, tick and reset; a line monitor decodes frames against a scoreboard.
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int OS           = 16;
    localparam int CLK_PER_TICK = 4;
    localparam int NDUT         = 4;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic            tick  = 1'b0;
    logic [NDUT-1:0] valid = '0;
    logic [8:0]      data [NDUT];
    logic [NDUT-1:0] ready, busy, done, txl;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1), .OVERSAMPLE(OS)) u_8n1 (
        .clk(clk), .reset(reset), .tick(tick), .tx_data(data[0][7:0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx(txl[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_frame #(.DATA_BITS(7), .PARITY(PARITY_EVEN), .STOP_BITS(1), .OVERSAMPLE(OS)) u_7e1 (
        .clk(clk), .reset(reset), .tick(tick), .tx_data(data[1][6:0]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx(txl[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_frame #(.DATA_BITS(7), .PARITY(PARITY_ODD), .STOP_BITS(1), .OVERSAMPLE(OS)) u_7o1 (
        .clk(clk), .reset(reset), .tick(tick), .tx_data(data[2][6:0]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx(txl[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx_frame #(.DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(2), .OVERSAMPLE(OS)) u_8n2 (
        .clk(clk), .reset(reset), .tick(tick), .tx_data(data[3][7:0]), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .tx(txl[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    // Frame bits are in line order: bit 0 is the start bit.
    typedef struct {
        int          dut;
        logic [15:0] bits;
        int          len;
    } frame_t;

    typedef struct {
        int          dut;
        logic [8:0]  word;
        logic [15:0] bits;
        int          len;
    } vec_t;

    frame_t exp_q[$];
    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int phase  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Inputs (tick included) change on the falling edge; outputs are read there too.
    task automatic next_cycle();
        @(negedge clk);
        tick  = (phase == CLK_PER_TICK - 1);
        phase = (phase + 1) % CLK_PER_TICK;
        cyc++;
    endtask

    task automatic push_exp(input int d, input logic [15:0] bits, input int len);
        frame_t f;
        f.dut  = d;
        f.bits = bits;
        f.len  = len;
        exp_q.push_back(f);
    endtask

    task automatic wait_ready(input int d);
        int guard;
        guard = 0;
        while (!ready[d] && guard < 2000) begin
            next_cycle();
            guard++;
        end
    endtask

    // lat = clk edges from the handshake edge to the edge that raises tx_done.
    task automatic wait_done(input int d, input int hs, output int lat, output bit early);
        early = 1'b0;
        while (!done[d] && (cyc - hs) < 3000) begin
            if (ready[d] || !busy[d]) early = 1'b1;
            next_cycle();
        end
        lat = cyc - hs - 1;
    endtask

    // Line monitor: counts ticks per bit and rebuilds each frame from tx.
    bit          in_fr [NDUT];
    bit          ghost [NDUT];
    bit          bad   [NDUT];
    int          bitpos[NDUT];
    int          tcnt  [NDUT];
    int          flen  [NDUT];
    logic        cur   [NDUT];
    logic [15:0] got   [NDUT];

    initial begin
        frame_t f;
        for (int i = 0; i < NDUT; i++) in_fr[i] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++) begin
                if (reset) begin
                    in_fr[i] = 1'b0;
                end else if (!in_fr[i]) begin
                    if (txl[i] == 1'b0) begin
                        in_fr[i]  = 1'b1;
                        bitpos[i] = 0;
                        tcnt[i]   = 0;
                        cur[i]    = 1'b0;
                        got[i]    = '0;
                        bad[i]    = 1'b0;
                        if (exp_q.size() == 0 || exp_q[0].dut != i) begin
                            ghost[i] = 1'b1;
                            flen[i]  = 10;
                            checks++;
                            errs++;
                            $display("FAIL unexpected_frame dut%0d: got start bit, expected idle line", i);
                        end else begin
                            ghost[i] = 1'b0;
                            flen[i]  = exp_q[0].len;
                        end
                    end
                end else begin
                    if (tick) tcnt[i]++;
                    if (tcnt[i] == OS) begin
                        got[i][bitpos[i]] = cur[i];
                        bitpos[i]++;
                        tcnt[i] = 0;
                        if (bitpos[i] == flen[i]) begin
                            in_fr[i] = 1'b0;
                            if (!ghost[i]) begin
                                f = exp_q.pop_front();
                                check($sformatf("frame_bits_dut%0d", i), got[i], f.bits);
                                check($sformatf("bit_width_dut%0d", i), bad[i], 1'b0);
                                check($sformatf("done_at_last_stop_dut%0d", i), done[i], 1'b1);
                            end
                        end else begin
                            cur[i] = txl[i];
                            if (done[i]) bad[i] = 1'b1;
                        end
                    end else if (txl[i] !== cur[i] || done[i]) begin
                        bad[i] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        int   hs, hs2, lat, guard;
        bit   early, quiet;

        vecs[0]  = '{0, 9'h055, 16'h02AA, 10};
        vecs[1]  = '{0, 9'h000, 16'h0200, 10};
        vecs[2]  = '{0, 9'h0FF, 16'h03FE, 10};
        vecs[3]  = '{1, 9'h003, 16'h0206, 10};
        vecs[4]  = '{2, 9'h003, 16'h0306, 10};
        vecs[5]  = '{1, 9'h001, 16'h0302, 10};
        vecs[6]  = '{2, 9'h001, 16'h0202, 10};
        vecs[7]  = '{1, 9'h07F, 16'h03FE, 10};
        vecs[8]  = '{2, 9'h07F, 16'h02FE, 10};
        vecs[9]  = '{3, 9'h0FF, 16'h07FE, 11};
        vecs[10] = '{3, 9'h00F, 16'h061E, 11};

        for (int i = 0; i < NDUT; i++) data[i] = '0;
        repeat (3) next_cycle();
        check("reset_tx", txl, 4'hF);
        check("reset_ready", ready, 4'hF);
        check("reset_busy", busy, 4'h0);
        check("reset_done", done, 4'h0);
        reset = 1'b0;
        next_cycle();

        for (int v = 0; v < 11; v++) begin
            wait_ready(vecs[v].dut);
            data[vecs[v].dut]  = vecs[v].word;
            valid[vecs[v].dut] = 1'b1;
            push_exp(vecs[v].dut, vecs[v].bits, vecs[v].len);
            hs = cyc;
            next_cycle();
            valid[vecs[v].dut] = 1'b0;
            wait_done(vecs[v].dut, hs, lat, early);
            check_range($sformatf("latency_vec%0d", v), lat,
                        vecs[v].len * OS * CLK_PER_TICK - 4, vecs[v].len * OS * CLK_PER_TICK + 4);
            check($sformatf("ready_low_vec%0d", v), early, 1'b0);
        end

        // Handshake in a tick cycle, then a tx_data change and valid pulse mid-frame.
        wait_ready(0);
        guard = 0;
        do begin
            next_cycle();
            guard++;
        end while (tick !== 1'b1 && guard < 10);
        data[0]  = 9'h055;
        valid[0] = 1'b1;
        push_exp(0, 16'h02AA, 10);
        hs = cyc;
        next_cycle();
        valid[0] = 1'b0;
        repeat (300) next_cycle();
        data[0]  = 9'h0FF;
        valid[0] = 1'b1;
        next_cycle();
        valid[0] = 1'b0;
        data[0]  = 9'h000;
        wait_done(0, hs, lat, early);
        check("tick_in_handshake_latency", lat, 10 * OS * CLK_PER_TICK);
        check("ready_low_robust", early, 1'b0);
        quiet = 1'b1;
        repeat (200) begin
            next_cycle();
            if (txl[0] !== 1'b1 || done[0] !== 1'b0) quiet = 1'b0;
        end
        check("no_extra_frame", quiet, 1'b1);

        // Back-to-back 0x12, 0x34 with tx_valid held high.
        wait_ready(0);
        data[0]  = 9'h012;
        valid[0] = 1'b1;
        push_exp(0, 16'h0224, 10);
        push_exp(0, 16'h0268, 10);
        hs = cyc;
        next_cycle();
        data[0] = 9'h034;
        wait_done(0, hs, lat, early);
        check_range("b2b_first_latency", lat, 636, 644);
        check("b2b_tx_high_at_done", txl[0], 1'b1);
        check("b2b_ready_at_done", ready[0], 1'b1);
        hs2 = cyc;
        next_cycle();
        valid[0] = 1'b0;
        check("b2b_start_1clk", txl[0], 1'b0);
        check("b2b_busy", busy[0], 1'b1);
        wait_done(0, hs2, lat, early);
        check_range("b2b_second_latency", lat, 636, 644);
        check("b2b_ready_low", early, 1'b0);
        next_cycle();
        check("scoreboard_drained", exp_q.size(), 0);

        // Reset while the 0x0A5 frame is in data bit 1 (a zero).
        wait_ready(0);
        data[0]  = 9'h0A5;
        valid[0] = 1'b1;
        push_exp(0, 16'h034A, 10);
        hs = cyc;
        next_cycle();
        valid[0] = 1'b0;
        repeat (150) next_cycle();
        check("pre_reset_tx_bit1", txl[0], 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_tx", txl[0], 1'b1);
        exp_q.delete();
        repeat (2) next_cycle();
        reset = 1'b0;
        next_cycle();
        check("post_reset_ready", ready[0], 1'b1);
        check("post_reset_busy", busy[0], 1'b0);
        quiet = 1'b1;
        repeat (800) begin
            next_cycle();
            if (txl[0] !== 1'b1 || done[0] !== 1'b0) quiet = 1'b0;
        end
        check("no_done_after_reset", quiet, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
